rr_arbiter_16: RTL and testbench
================================

// Module: rr_arbiter_16
// PURPOSE
//  Round-robin arbiter sharing one resource between 16 requesters. The 16-bit request vector
//  is encoded into a one-hot grant plus a 4-bit grant index, with fair rotation and grant hold.
//  Sits in front of the shared datapath; gnt_idx drives its input-select mux.
// PARAMETERS
//  N_REQ     16  number of requesters (fixed at 16 for this revision)
//  IDX_W      4  grant index width, log2(N_REQ)
//  MAX_HOLD   8  max cycles one grant may be held (used only when ARB_TIMEOUT_EN is defined)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  en         in   1   arbitration enable; 0 = issue no new grants
//  req        in  16   request vector, bit k = requester k
//  done       in   1   pulse from granted requester: transfer complete, release grant
//  gnt        out 16   one-hot grant, registered
//  gnt_idx    out  4   binary index of granted requester, registered
//  gnt_valid  out  1   1 while a grant is held (== |gnt)
//  timeout    out  1   1-cycle pulse when a grant is revoked by the hold limit
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0.
//  FSM states: IDLE, BUSY.
//   IDLE: if en & |req -> winner = first set req bit at or above ptr, searching upward with
//         wrap 15->0. Next edge: gnt=1<<winner, gnt_idx=winner, gnt_valid=1, ptr=winner+1
//         (mod 16), state=BUSY. Otherwise stay IDLE with all outputs 0.
//   BUSY: hold gnt/gnt_idx constant. Release when done=1 OR req[gnt_idx]=0.
//         Release edge: gnt=0, gnt_valid=0, state=IDLE.
//  Latency: req to gnt = 1 cycle. Back-to-back grants are separated by exactly 1 IDLE cycle.
//  The pointer advances only when a grant is issued. A requester just served has the lowest
//  priority in the next arbitration.
//  en=0 while BUSY: the current grant runs to release; no new grant is issued afterwards.
//  done while IDLE: ignored. done plus new req in the same cycle: release first;
//   re-arbitration happens in the following IDLE cycle.
//  req=16'hFFFF held continuously: grants cycle 0,1,2,...,15,0 (wrap).
//  Only req sampled in IDLE matters; req changes during BUSY other than the granted bit
//   have no effect.
//  gnt is always zero or one-hot; gnt_idx keeps its last value while gnt_valid=0.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: a hold counter (width enough to hold MAX_HOLD) clears on grant
//   and increments each BUSY cycle. If MAX_HOLD cycles elapse without release, the next
//   edge forces release and pulses timeout=1 for 1 cycle. The pointer is still the
//   revoked index+1.
//  ARB_TIMEOUT_EN undefined: there is no counter, timeout is tied 0, and a grant is held
//   until done or req drop.
// STRUCTURE
//  Package rr_arb_pkg: N_REQ, IDX_W, state encoding (IDLE=1'b0, BUSY=1'b1), MAX_HOLD default.
//  Sub-module rr_prio_enc16: combinational 16->4 priority encoder with valid and start-pointer
//   input (rotate, encode lowest set bit, un-rotate). The top holds the FSM, pointer, output
//   registers and the optional counter.
// TESTING
//  1 Reset: rst_n=0 mid-BUSY with gnt=16'h0010 -> gnt=0, gnt_valid=0, ptr=0 immediately,
//    without waiting for clk.
//  2 Single: ptr=0, req=16'h0100, en=1 -> next cycle gnt=16'h0100, gnt_idx=4'd8;
//    done pulse -> gnt=0.
//  3 Fairness: req=16'hFFFF held, done after 2 BUSY cycles each -> gnt_idx sequence
//    0,1,...,15,0 with one IDLE gap between grants.
//  4 Rotation: grant to idx 5, then req=16'h0021 -> next grant idx 0 (pointer=6 wraps past 15).
//  5 Enable/drop: en=0 with req=16'h0003 -> no grant. During BUSY on idx 1, drop req[1]
//    -> release next edge.
//  6 Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): grant idx 3, no done -> release after 8 BUSY
//    cycles, timeout high for 1 cycle. Rebuilt with ARB_TIMEOUT_EN undefined -> grant held
//    for 100 cycles, timeout stays 0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter:
// requester count, index width, hold limit and the FSM state encoding.
// The hold limit is only used when ARB_TIMEOUT_EN is defined.
package rr_arb_pkg;

    localparam int N_REQ    = 16;
    localparam int IDX_W    = 4;
    localparam int MAX_HOLD = 8;

    // Hold counter must be able to represent MAX_HOLD itself
    localparam int HOLD_W   = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_16_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// master: requester side (drives en/req/done); slave: arbiter side.
interface rr_arbiter_16_if;
    import rr_arb_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output en, req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_prio_enc16.sv
// Combinational 16->4 rotating priority encoder. The request vector is
// rotated so the start pointer lands at bit 0, the lowest set bit is found,
// and the pointer is added back (mod 16) to give the absolute index.
module rr_prio_enc16
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [N_REQ-1:0] rotReq;
    logic [IDX_W-1:0] rotIdx;

    // Rotate right by the pointer, pick the lowest set bit, then un-rotate
    always_comb begin
        rotReq = N_REQ'({req_i, req_i} >> ptr_i);
        rotIdx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotReq[i]) begin
                rotIdx = IDX_W'(i);
            end
        end
        idx_o   = rotIdx + ptr_i;
        valid_o = |req_i;
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters: IDLE/BUSY FSM, rotating priority
// pointer and registered one-hot grant plus binary index. A grant is held
// until done or until the granted request drops.
// Optional feature macro: ARB_TIMEOUT_EN -- adds a hold counter that revokes
// a grant after MAX_HOLD busy cycles and pulses timeout for one cycle.
module rr_arbiter_16
    import rr_arb_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    rr_arbiter_16_if.slave bus
);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] encIdx;
    logic             encValid;
`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
    logic              timeout_q, timeout_d;
`endif

    rr_prio_enc16 u_enc (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .idx_o   (encIdx),
        .valid_o (encValid)
    );

    // Next-state logic: grant from IDLE, release from BUSY
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        holdCnt_d = holdCnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.en && encValid) begin
                    state_d = BUSY;
                    gnt_d   = N_REQ'(1) << encIdx;
                    idx_d   = encIdx;
                    ptr_d   = encIdx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
                    holdCnt_d = '0;
`endif
                end
            end
            BUSY: begin
                if (bus.done || !bus.req[idx_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (holdCnt_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    holdCnt_d = holdCnt_q + HOLD_W'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State, pointer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter and one-cycle timeout pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdCnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            holdCnt_q <= holdCnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = (state_q == BUSY);

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed testbench for rr_arbiter_16. Inputs change 1ns after the rising
// edge and outputs are sampled at that same point, well clear of the edge.
module tb_rr_arbiter_16;

    logic clk;
    logic rst_n;
    int   vecCount;
    int   errCount;

    rr_arbiter_16_if bus ();

    rr_arbiter_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        repeat (2) tick();
        vecCount++;
        if (bus.gnt !== 16'h0000) begin errCount++; $display("[TB] FAIL reset_gnt: got %h want %h", bus.gnt, 16'h0000); end
        vecCount++;
        if (bus.gnt_idx !== 4'd0) begin errCount++; $display("[TB] FAIL reset_idx: got %0d want %0d", bus.gnt_idx, 0); end
        vecCount++;
        if (bus.gnt_valid !== 1'b0) begin errCount++; $display("[TB] FAIL reset_valid: got %b want %b", bus.gnt_valid, 1'b0); end
        vecCount++;
        if (bus.timeout !== 1'b0) begin errCount++; $display("[TB] FAIL reset_timeout: got %b want %b", bus.timeout, 1'b0); end
        rst_n = 1'b1;
        tick();
        bus.req = 16'h0010;
        bus.en  = 1'b1;
        tick();
        vecCount++;
        if (bus.gnt !== 16'h0010) begin errCount++; $display("[TB] FAIL busy_before_reset: got %h want %h", bus.gnt, 16'h0010); end
        // Assert reset between clock edges; outputs must clear at once
        #3;
        rst_n = 1'b0;
        #1;
        vecCount++;
        if (bus.gnt !== 16'h0000) begin errCount++; $display("[TB] FAIL async_reset_gnt: got %h want %h", bus.gnt, 16'h0000); end
        vecCount++;
        if (bus.gnt_valid !== 1'b0) begin errCount++; $display("[TB] FAIL async_reset_valid: got %b want %b", bus.gnt_valid, 1'b0); end
        vecCount++;
        if (bus.gnt_idx !== 4'd0) begin errCount++; $display("[TB] FAIL async_reset_idx: got %0d want %0d", bus.gnt_idx, 0); end
        // Pointer back at 0: with req 0 and 15 set, requester 0 must win
        bus.req = 16'h8001;
        #2;
        rst_n = 1'b1;
        tick();
        vecCount++;
        if (bus.gnt_idx !== 4'd0 || bus.gnt !== 16'h0001) begin errCount++; $display("[TB] FAIL reset_ptr: got idx %0d gnt %h want idx 0 gnt 0001", bus.gnt_idx, bus.gnt); end
        bus.req = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 16'h0100;
        bus.en  = 1'b1;
        tick();
        vecCount++;
        if (bus.gnt !== 16'h0100) begin errCount++; $display("[TB] FAIL single_gnt: got %h want %h", bus.gnt, 16'h0100); end
        vecCount++;
        if (bus.gnt_idx !== 4'd8) begin errCount++; $display("[TB] FAIL single_idx: got %0d want %0d", bus.gnt_idx, 8); end
        vecCount++;
        if (bus.gnt_valid !== 1'b1) begin errCount++; $display("[TB] FAIL single_valid: got %b want %b", bus.gnt_valid, 1'b1); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = '0;
        vecCount++;
        if (bus.gnt !== 16'h0000 || bus.gnt_valid !== 1'b0) begin errCount++; $display("[TB] FAIL single_release: got gnt %h valid %b want 0000/0", bus.gnt, bus.gnt_valid); end
        vecCount++;
        if (bus.gnt_idx !== 4'd8) begin errCount++; $display("[TB] FAIL single_idx_hold: got %0d want %0d", bus.gnt_idx, 8); end
        // done while IDLE has no effect
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        vecCount++;
        if (bus.gnt_valid !== 1'b0) begin errCount++; $display("[TB] FAIL idle_done: got valid %b want 0", bus.gnt_valid); end
    endtask

    task automatic test_fairness();
        logic [3:0]  expIdx;
        logic [15:0] expGnt;
        do_reset();
        bus.req = 16'hFFFF;
        bus.en  = 1'b1;
        for (int g = 0; g < 17; g++) begin
            expIdx = 4'(g % 16);
            expGnt = 16'h0001 << expIdx;
            tick();
            vecCount++;
            if (bus.gnt_idx !== expIdx || bus.gnt !== expGnt) begin errCount++; $display("[TB] FAIL fair_grant%0d: got idx %0d gnt %h want idx %0d gnt %h", g, bus.gnt_idx, bus.gnt, expIdx, expGnt); end
            tick();
            vecCount++;
            if (bus.gnt !== expGnt) begin errCount++; $display("[TB] FAIL fair_hold%0d: got %h want %h", g, bus.gnt, expGnt); end
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            vecCount++;
            if (bus.gnt_valid !== 1'b0 || bus.gnt !== 16'h0000) begin errCount++; $display("[TB] FAIL fair_gap%0d: got valid %b gnt %h want 0/0000", g, bus.gnt_valid, bus.gnt); end
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_rotation();
        do_reset();
        bus.req = 16'h0020;
        bus.en  = 1'b1;
        tick();
        vecCount++;
        if (bus.gnt_idx !== 4'd5) begin errCount++; $display("[TB] FAIL rot_first: got %0d want %0d", bus.gnt_idx, 5); end
        bus.req  = 16'h0021;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        vecCount++;
        if (bus.gnt_valid !== 1'b0) begin errCount++; $display("[TB] FAIL rot_release: got valid %b want 0", bus.gnt_valid); end
        tick();
        vecCount++;
        if (bus.gnt_idx !== 4'd0 || bus.gnt !== 16'h0001) begin errCount++; $display("[TB] FAIL rot_wrap: got idx %0d gnt %h want idx 0 gnt 0001", bus.gnt_idx, bus.gnt); end
        bus.req = '0;
        tick();
    endtask

    task automatic test_enable_drop();
        // Pointer is 1 after the rotation test
        bus.en  = 1'b0;
        bus.req = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecCount++;
            if (bus.gnt_valid !== 1'b0 || bus.gnt !== 16'h0000) begin errCount++; $display("[TB] FAIL en_off%0d: got valid %b gnt %h want 0/0000", i, bus.gnt_valid, bus.gnt); end
        end
        bus.en = 1'b1;
        tick();
        vecCount++;
        if (bus.gnt_idx !== 4'd1 || bus.gnt !== 16'h0002) begin errCount++; $display("[TB] FAIL en_grant: got idx %0d gnt %h want idx 1 gnt 0002", bus.gnt_idx, bus.gnt); end
        tick();
        vecCount++;
        if (bus.gnt !== 16'h0002) begin errCount++; $display("[TB] FAIL drop_hold: got %h want %h", bus.gnt, 16'h0002); end
        bus.req = 16'h0001;
        tick();
        vecCount++;
        if (bus.gnt_valid !== 1'b0) begin errCount++; $display("[TB] FAIL drop_release: got valid %b want 0", bus.gnt_valid); end
        // Pointer 2: requester 0 wins by wrap; then en drops mid-grant
        tick();
        vecCount++;
        if (bus.gnt_idx !== 4'd0 || bus.gnt !== 16'h0001) begin errCount++; $display("[TB] FAIL en_wrap: got idx %0d gnt %h want idx 0 gnt 0001", bus.gnt_idx, bus.gnt); end
        bus.en = 1'b0;
        tick();
        vecCount++;
        if (bus.gnt !== 16'h0001) begin errCount++; $display("[TB] FAIL en_off_busy: got %h want %h", bus.gnt, 16'h0001); end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        vecCount++;
        if (bus.gnt_valid !== 1'b0) begin errCount++; $display("[TB] FAIL en_off_release: got valid %b want 0", bus.gnt_valid); end
        tick();
        vecCount++;
        if (bus.gnt_valid !== 1'b0) begin errCount++; $display("[TB] FAIL en_off_nogrant: got valid %b want 0", bus.gnt_valid); end
        bus.req = '0;
    endtask

    task automatic test_timeout();
        do_reset();
        bus.req = 16'h0008;
        bus.en  = 1'b1;
        tick();
        vecCount++;
        if (bus.gnt_idx !== 4'd3 || bus.gnt_valid !== 1'b1) begin errCount++; $display("[TB] FAIL to_grant: got idx %0d valid %b want idx 3 valid 1", bus.gnt_idx, bus.gnt_valid); end
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) begin
            tick();
            vecCount++;
            if (bus.gnt_valid !== 1'b1 || bus.timeout !== 1'b0) begin errCount++; $display("[TB] FAIL to_busy%0d: got valid %b timeout %b want 1/0", c, bus.gnt_valid, bus.timeout); end
        end
        tick();
        vecCount++;
        if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b1) begin errCount++; $display("[TB] FAIL to_revoke: got valid %b timeout %b want 0/1", bus.gnt_valid, bus.timeout); end
        tick();
        vecCount++;
        if (bus.timeout !== 1'b0 || bus.gnt_idx !== 4'd3 || bus.gnt_valid !== 1'b1) begin errCount++; $display("[TB] FAIL to_regrant: got timeout %b idx %0d valid %b want 0/3/1", bus.timeout, bus.gnt_idx, bus.gnt_valid); end
`else
        for (int c = 0; c < 100; c++) begin
            tick();
            vecCount++;
            if (bus.gnt !== 16'h0008 || bus.timeout !== 1'b0) begin errCount++; $display("[TB] FAIL hold%0d: got gnt %h timeout %b want 0008/0", c, bus.gnt, bus.timeout); end
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        vecCount++;
        if (bus.gnt_valid !== 1'b0) begin errCount++; $display("[TB] FAIL hold_release: got valid %b want 0", bus.gnt_valid); end
`endif
        bus.req = '0;
        tick();
    endtask

    // Scenario sequence
    initial begin
        vecCount = 0;
        errCount = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_rotation();
        test_enable_drop();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
